// File: rtl/div_8_if.sv
// div_8_if: request/result bundle for the 8-bit sequential divider.
interface div_8_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_8.sv
// div_8: 8-bit unsigned restoring divider, one quotient bit per clock.
module div_8 (
    input logic     clk,
    input logic     rst,
    div_8_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state_q;
    logic [7:0] p_q, p_d, q_q, q_d, dvsr_q, quot_q, rem_q;
    logic [2:0] cnt_q;
    logic       busy_q, done_q, dbz_q, no_borrow;
    logic [8:0] s;
    // P < divisor always holds, so the trial difference fits in 8 bits
    always_comb begin
        s         = {p_q, q_q[7]};
        no_borrow = s >= {1'b0, dvsr_q};
        p_d       = no_borrow ? s[7:0] - dvsr_q : s[7:0];
        q_d       = {q_q[6:0], no_borrow};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && bus.divisor != 8'd0) begin
                        dvsr_q  <= bus.divisor;
                        p_q     <= '0;
                        q_q     <= bus.dividend;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else if (bus.start) begin
                        quot_q  <= 8'hFF;
                        rem_q   <= bus.dividend;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        quot_q  <= q_d;
                        rem_q   <= p_d;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_8.sv
// tb_div_8: randomized and directed checks of div_8 against a/b, a%b arithmetic.
module tb_div_8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   overlap = 0;
    div_8_if bus ();
    div_8 u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.busy && bus.done) overlap++;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    // Entered at the negedge after the accepting edge; leaves one cycle after done.
    task automatic wait_res(input logic [7:0] a, input logic [7:0] b);
        int busy_n = 0;
        int done_at = 0;
        for (int k = 1; k <= 14 && done_at == 0; k++) begin
            if (bus.busy) busy_n++;
            if (bus.done) done_at = k;
            else @(negedge clk);
        end
        check("latency", done_at, b == 0 ? 1 : 9);
        check("busy_cycles", busy_n, b == 0 ? 0 : 8);
        check("quotient", bus.quotient, b == 0 ? 8'hFF : a / b);
        check("remainder", bus.remainder, b == 0 ? a : a % b);
        check("div_by_zero", bus.div_by_zero, b == 0);
        @(negedge clk);
        check("done_pulse", bus.done, 0);
        check("held_quotient", bus.quotient, b == 0 ? 8'hFF : a / b);
    endtask
    task automatic run(input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor = 8'($urandom);
        wait_res(a, b);
    endtask
    initial begin
        int seen_done;
        bus.start = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor = 8'd3;
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_outputs", {bus.quotient, bus.remainder, 7'd0, bus.div_by_zero}, 0);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {bus.busy, bus.done}, 0);
        run(8'd200, 8'd7);
        run(8'd255, 8'd1);
        run(8'd5, 8'd9);
        run(8'd0, 8'd3);
        run(8'd255, 8'd255);
        run(8'd128, 8'd2);
        run(8'd100, 8'd0);
        run(8'd9, 8'd3);
        // operands change and start stays high while running
        bus.start = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        bus.dividend = 8'd1;
        bus.divisor = 8'd1;
        wait_res(8'd200, 8'd7);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_res(8'd1, 8'd1);
        // abort on the 4th RUN cycle
        bus.start = 1'b1;
        bus.dividend = 8'd77;
        bus.divisor = 8'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_outputs", {bus.quotient, bus.remainder, 7'd0, bus.div_by_zero}, 0);
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        run(8'd77, 8'd5);
        repeat (200) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            run(a, b);
        end
        check("busy_done_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
